// File: rtl/nv_nvdla_mcif_read_ig_arb_pipe_gen.sv
// In-order request pipe between the bpt read splitter and the ingress arbiter.
// Every output is driven from registered state, so neither side sees a combinational path.
module nv_nvdla_mcif_read_ig_arb_pipe_gen #(
  parameter int DW    = 75,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          bpt2arb_req_valid,
  output logic          bpt2arb_req_ready,
  input  logic [DW-1:0] bpt2arb_req_pd,
  output logic          arb_src_vld,
  input  logic          arb_src_rdy,
  output logic [DW-1:0] arb_src_pd,
  input  logic          pipe_flush,
  output logic [CW-1:0] pipe_occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] head;
  logic          push;
  logic          pop;

  // Handshake: a beat moves only on a rising edge where valid && ready; valid and
  // ready each come from registered count, and a full pipe never accepts in the pop cycle.
  assign bpt2arb_req_ready = (count != CW'(DEPTH));
  assign arb_src_vld       = (count != '0);
  assign push              = bpt2arb_req_valid && bpt2arb_req_ready;
  assign pop               = arb_src_vld && arb_src_rdy;
  assign pipe_occupancy    = count;
  assign arb_src_pd        = head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (pipe_flush) begin
      // Flush wins over any same-cycle push; a same-cycle pop has already been taken downstream.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage is intentionally not reset; only the addressed entry is written.
  always_ff @(posedge nvdla_core_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !pipe_flush && (wr_ptr == PW'(i))) mem[i] <= bpt2arb_req_pd;
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == PW'(i)) head = mem[i];
    end
  end

endmodule

// File: tb/tb_nv_nvdla_mcif_read_ig_arb_pipe_gen.sv
// Bench for the ingress arbiter pipe: three instances (DEPTH 2, 3, 1) checked against a
// queue-based reference model by a negedge monitor.
module tb_nv_nvdla_mcif_read_ig_arb_pipe_gen;

  localparam int DW = 75;
  localparam int NI = 3;
  localparam int DEPTHS [NI] = '{2, 3, 1};

  logic          clk;
  logic          rstn;
  logic          in_vld  [NI];
  logic [DW-1:0] in_pd   [NI];
  logic          req_rdy [NI];
  logic          src_vld [NI];
  logic [DW-1:0] src_pd  [NI];
  logic          out_rdy [NI];
  logic          flush   [NI];
  logic [1:0]    occ_d2;
  logic [1:0]    occ_d3;
  logic [0:0]    occ_d1;

  logic [DW-1:0] exp_q_d2[$];
  logic [DW-1:0] exp_q_d3[$];
  logic [DW-1:0] exp_q_d1[$];

  int tests;
  int fails;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  nv_nvdla_mcif_read_ig_arb_pipe_gen #(.DW(DW), .DEPTH(2)) u_d2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .bpt2arb_req_valid(in_vld[0]), .bpt2arb_req_ready(req_rdy[0]), .bpt2arb_req_pd(in_pd[0]),
    .arb_src_vld(src_vld[0]), .arb_src_rdy(out_rdy[0]), .arb_src_pd(src_pd[0]),
    .pipe_flush(flush[0]), .pipe_occupancy(occ_d2));

  nv_nvdla_mcif_read_ig_arb_pipe_gen #(.DW(DW), .DEPTH(3)) u_d3 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .bpt2arb_req_valid(in_vld[1]), .bpt2arb_req_ready(req_rdy[1]), .bpt2arb_req_pd(in_pd[1]),
    .arb_src_vld(src_vld[1]), .arb_src_rdy(out_rdy[1]), .arb_src_pd(src_pd[1]),
    .pipe_flush(flush[1]), .pipe_occupancy(occ_d3));

  nv_nvdla_mcif_read_ig_arb_pipe_gen #(.DW(DW), .DEPTH(1)) u_d1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .bpt2arb_req_valid(in_vld[2]), .bpt2arb_req_ready(req_rdy[2]), .bpt2arb_req_pd(in_pd[2]),
    .arb_src_vld(src_vld[2]), .arb_src_rdy(out_rdy[2]), .arb_src_pd(src_pd[2]),
    .pipe_flush(flush[2]), .pipe_occupancy(occ_d1));

  // ---------------- reference model storage ----------------
  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q_d2.size();
      1:       return exp_q_d3.size();
      default: return exp_q_d1.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] q_front(input int k);
    case (k)
      0:       return exp_q_d2[0];
      1:       return exp_q_d3[0];
      default: return exp_q_d1[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(exp_q_d2.pop_front());
      1:       void'(exp_q_d3.pop_front());
      default: void'(exp_q_d1.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input logic [DW-1:0] d);
    case (k)
      0:       exp_q_d2.push_back(d);
      1:       exp_q_d3.push_back(d);
      default: exp_q_d1.push_back(d);
    endcase
  endtask

  task automatic q_clear(input int k);
    case (k)
      0:       exp_q_d2.delete();
      1:       exp_q_d3.delete();
      default: exp_q_d1.delete();
    endcase
  endtask

  function automatic int occ_val(input int k);
    case (k)
      0:       return int'(occ_d2);
      1:       return int'(occ_d3);
      default: return int'(occ_d1);
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d (depth %0d): got %h expected %h", name, k, DEPTHS[k], act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Inputs change 1ns after posedge, so at negedge they hold what the next edge will sample.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NI; k++) q_clear(k);
    end else begin
      for (int k = 0; k < NI; k++) begin
        automatic int  sz      = q_size(k);
        automatic bit  do_pop  = (sz != 0) && out_rdy[k];
        automatic bit  do_push = in_vld[k] && (sz != DEPTHS[k]) && !flush[k];
        check("vld", k, DW'(src_vld[k]), DW'(sz != 0));
        check("ready", k, DW'(req_rdy[k]), DW'(sz != DEPTHS[k]));
        check("occupancy", k, DW'(occ_val(k)), DW'(sz));
        if (sz != 0) check("pd", k, src_pd[k], q_front(k));
        if (do_pop)   q_pop(k);
        if (do_push)  q_push(k, in_pd[k]);
        if (flush[k]) q_clear(k);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_pd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Present d and hold it until the edge that accepts it; valid stays high on return.
  task automatic send(input int k, input logic [DW-1:0] d);
    in_vld[k] = 1'b1;
    in_pd[k]  = d;
    for (int n = 0; n < 200; n++) begin
      if (req_rdy[k]) begin
        tick();
        return;
      end
      tick();
    end
    check("send_timeout", k, DW'(0), DW'(1));
  endtask

  task automatic drain(input int k);
    in_vld[k]  = 1'b0;
    out_rdy[k] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (q_size(k) == 0 && !src_vld[k]) return;
      tick();
    end
    check("drain_timeout", k, DW'(0), DW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    automatic bit hold [NI] = '{0, 0, 0};
    automatic int pops = 0;
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_vld[k] = 1'b0; in_pd[k] = '0; out_rdy[k] = 1'b0; flush[k] = 1'b0;
    end
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      check("reset_vld", k, DW'(src_vld[k]), DW'(0));
      check("reset_ready", k, DW'(req_rdy[k]), DW'(1));
      check("reset_occ", k, DW'(occ_val(k)), DW'(0));
    end
    rstn = 1'b1;
    tick();

    // Streaming through DEPTH=2 with the sink always ready.
    out_rdy[0] = 1'b1;
    send(0, DW'(32'h1));
    send(0, DW'(32'h2));
    send(0, DW'(32'h3));
    in_vld[0] = 1'b0;
    drain(0);

    // Sink stalled: fill, hold 0xC upstream, then release.
    out_rdy[0] = 1'b0;
    send(0, DW'(32'hA));
    send(0, DW'(32'hB));
    in_vld[0] = 1'b1;
    in_pd[0]  = DW'(32'hC);
    repeat (3) tick();
    check("stall_occ", 0, DW'(occ_val(0)), DW'(2));
    check("stall_ready", 0, DW'(req_rdy[0]), DW'(0));
    out_rdy[0] = 1'b1;
    send(0, DW'(32'hC));
    in_vld[0] = 1'b0;
    drain(0);

    // Flush a full pipe while a push is offered.
    out_rdy[0] = 1'b0;
    send(0, DW'(32'h10));
    send(0, DW'(32'h11));
    in_vld[0] = 1'b1;
    in_pd[0]  = DW'(32'h5);
    flush[0]  = 1'b1;
    tick();
    flush[0]  = 1'b0;
    in_vld[0] = 1'b0;
    check("flush_occ", 0, DW'(occ_val(0)), DW'(0));
    check("flush_vld", 0, DW'(src_vld[0]), DW'(0));
    check("flush_ready", 0, DW'(req_rdy[0]), DW'(1));
    out_rdy[0] = 1'b1;
    repeat (4) tick();

    // DEPTH=1 with both sides always ready: one beat every two cycles.
    drain(2);
    for (int i = 0; i < 20; i++) begin
      check("d1_ready_toggle", 2, DW'(req_rdy[2]), DW'(i % 2 == 0));
      if (src_vld[2]) pops++;
      if (req_rdy[2]) in_pd[2] = rand_pd();
      in_vld[2] = 1'b1;
      tick();
    end
    in_vld[2] = 1'b0;
    check("d1_transfers", 2, DW'(pops), DW'(10));
    drain(2);

    // Random traffic on all three instances, with occasional flushes.
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (!hold[k]) begin
          in_vld[k] = ($urandom_range(0, 99) < 60);
          in_pd[k]  = rand_pd();
        end
        out_rdy[k] = ($urandom_range(0, 99) < 55);
        flush[k]   = ($urandom_range(0, 199) == 0);
        hold[k]    = in_vld[k] && !req_rdy[k] && !flush[k];
      end
      tick();
    end
    for (int k = 0; k < NI; k++) flush[k] = 1'b0;
    for (int k = 0; k < NI; k++) drain(k);

    // Asynchronous reset with two entries buffered.
    out_rdy[0] = 1'b0;
    send(0, DW'(32'h21));
    send(0, DW'(32'h22));
    in_vld[0] = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_vld", 0, DW'(src_vld[0]), DW'(0));
    check("async_rst_ready", 0, DW'(req_rdy[0]), DW'(1));
    check("async_rst_occ", 0, DW'(occ_val(0)), DW'(0));
    tick();
    tick();
    rstn = 1'b1;
    tick();
    out_rdy[0] = 1'b1;
    send(0, DW'(32'h7));
    in_vld[0] = 1'b0;
    begin
      automatic bit seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        if (src_vld[0]) begin
          seen = 1'b1;
          check("post_reset_first", 0, src_pd[0], DW'(32'h7));
        end else begin
          tick();
        end
      end
      if (!seen) check("post_reset_timeout", 0, DW'(0), DW'(1));
    end
    drain(0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_mcif_read_ig_arb_pipe_gen.md
NV_NVDLA_MCIF_READ_IG_ARB_PIPE_GEN -- requirements
Module: nv_nvdla_mcif_read_ig_arb_pipe_gen

Interface
REQ-001 Parameter DW, default 75, payload width in bits, legal range 1..256, SHALL size both pd ports.
REQ-002 Parameter DEPTH, default 2, buffer entries, legal range 1..8, SHALL set storage capacity.
REQ-003 Parameter CW, default $clog2(DEPTH+1), occupancy width, SHALL NOT be overridden by instantiators.
REQ-004 nvdla_core_clk  input  1  sole clock, all state on rising edge.
REQ-005 nvdla_core_rstn  input  1  reset, asynchronous assert, active-low; one clock, reset asynchronous active-low.
REQ-006 bpt2arb_req_valid  input  1  upstream request valid.
REQ-007 bpt2arb_req_ready  output  1  upstream ready.
REQ-008 bpt2arb_req_pd  input  DW  upstream payload.
REQ-009 arb_src_vld  output  1  downstream valid.
REQ-010 arb_src_rdy  input  1  downstream ready.
REQ-011 arb_src_pd  output  DW  downstream payload.
REQ-012 pipe_flush  input  1  synchronous discard of all buffered entries.
REQ-013 pipe_occupancy  output  CW  current entry count, 0..DEPTH.

Function
REQ-014 Block SHALL be an in-order FIFO pipe of DEPTH entries: registered write/read pointers (mod DEPTH) and registered count.
REQ-015 push = bpt2arb_req_valid && bpt2arb_req_ready; pop = arb_src_vld && arb_src_rdy; transfers SHALL occur only on the clock edge where the respective term is 1.
REQ-016 bpt2arb_req_ready SHALL equal (count != DEPTH) and SHALL depend only on flops, with no combinational path from arb_src_rdy.
REQ-017 arb_src_vld SHALL equal (count != 0); arb_src_pd SHALL equal the head entry; no combinational path from any input to arb_src_vld or arb_src_pd.
REQ-018 Minimum latency SHALL be 1 cycle: a payload pushed at edge N is presented on arb_src_pd after edge N.
REQ-019 No bypass: when count == DEPTH, a pop in cycle N SHALL NOT allow a push in cycle N; ready rises after the edge.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 Count update: +1 on push-only, -1 on pop-only, unchanged otherwise; it SHALL never exceed DEPTH or underflow.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-023 Sustained throughput SHALL be 1 transfer/cycle for DEPTH >= 2 with both sides always ready; for DEPTH == 1, 1 transfer per 2 cycles.
REQ-024 pipe_flush SHALL take priority: at the edge it is sampled high, count and both pointers SHALL go to 0 and any same-cycle push SHALL be discarded.
REQ-025 While pipe_flush is high, bpt2arb_req_ready and arb_src_vld SHALL still follow REQ-016/017 from registered state; downstream pops in that cycle are legal and complete.
REQ-026 Entries SHALL remain stable while buffered; unselected storage SHALL NOT be written.
REQ-027 pipe_occupancy SHALL equal the registered count.

Reset
REQ-028 Asserting nvdla_core_rstn low SHALL immediately clear count and pointers, giving arb_src_vld=0, bpt2arb_req_ready=1 and pipe_occupancy=0, regardless of clock.
REQ-029 Payload storage SHALL NOT be reset; arb_src_pd is don't-care while arb_src_vld=0.
REQ-030 Reset asserted mid-transfer SHALL drop all buffered entries; the first post-reset push SHALL be the first output.

Verification
REQ-031 DW=75, DEPTH=2, rdy=1, push 0x1,0x2,0x3 back-to-back -> vld from cycle 1, pd 0x1,0x2,0x3 on consecutive cycles, occupancy stays 1.
REQ-032 DEPTH=2, rdy=0, push 0xA,0xB,0xC -> ready=0 after second push, occupancy=2, 0xC held upstream; raise rdy -> 0xA,0xB,0xC in order, no loss or duplication.
REQ-033 DEPTH=3, random valid/rdy over 10k cycles -> scoreboard in-order match, occupancy never >3, pointers wrap correctly.
REQ-034 DEPTH=2, occupancy=2, pipe_flush=1 with push 0x5 and rdy=0 -> next cycle occupancy=0, vld=0, ready=1, 0x5 never output.
REQ-035 DEPTH=1, both sides always ready -> one transfer every 2 cycles, ready toggles 1,0,1,0.
REQ-036 Assert rstn low mid-stream with occupancy=2 -> vld=0, ready=1 and occupancy=0 asynchronously; after release push 0x7 -> first output 0x7.
